// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: class codes, one-hot
// bit positions, opcode width and the handshake FSM state type.
package decode_pkg;

    localparam int unsigned OPW = 23;

    localparam logic [3:0] CLS_BASE      = 4'd0;
    localparam logic [3:0] CLS_GRP1      = 4'd1;
    localparam logic [3:0] CLS_LIN_FIRST = 4'd2;
    localparam logic [3:0] CLS_LIN_LAST  = 4'd11;
    localparam logic [3:0] CLS_PAIR      = 4'd12;
    localparam logic [3:0] CLS_C13       = 4'd13;
    localparam logic [3:0] CLS_C14       = 4'd14;
    localparam logic [3:0] CLS_QUAD      = 4'd15;

    localparam logic [4:0] IDX_BASE = 5'd0;
    localparam logic [4:0] IDX_GRP1 = 5'd1;
    localparam logic [4:0] IDX_LIN  = 5'd5;
    localparam logic [4:0] IDX_PAIR = 5'd15;
    localparam logic [4:0] IDX_C13  = 5'd17;
    localparam logic [4:0] IDX_C14  = 5'd18;
    localparam logic [4:0] IDX_QUAD = 5'd19;

    typedef enum logic [1:0] {
        S_OPC,
        S_IMM,
        S_OUT
    } state_e;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational opcode decoder: class/sub fields to a 23-bit one-hot
// opcode plus an illegal flag (illegal bytes produce an all-zero one-hot).
module decode_comb
    import decode_pkg::*;
(
    input  logic [3:0]     cls,
    input  logic [1:0]     sub,
    output logic [OPW-1:0] onehot,
    output logic           illegal
);

    logic [4:0] idx;

    always_comb begin
        idx     = IDX_BASE;
        illegal = 1'b0;
        case (cls)
            CLS_BASE: idx = IDX_BASE;
            CLS_GRP1: idx = IDX_GRP1 + {3'b000, sub};
            CLS_PAIR: begin
                if (sub[1]) illegal = 1'b1;
                else        idx     = IDX_PAIR + {4'b0000, sub[0]};
            end
            CLS_C13:  idx = IDX_C13;
            CLS_C14:  idx = IDX_C14;
            CLS_QUAD: idx = IDX_QUAD + {3'b000, sub};
            // remaining classes CLS_LIN_FIRST..CLS_LIN_LAST map linearly
            default:  idx = IDX_LIN + ({1'b0, cls} - {1'b0, CLS_LIN_FIRST});
        endcase
        onehot = illegal ? '0 : (OPW'(1) << idx);
    end

endmodule

// File: rtl/decode_stage.sv
// Byte-stream instruction decode stage: optional immediate byte per class,
// registered decoded outputs with valid/ready handshake and saturating counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned IW       = 8,
    parameter int unsigned CW       = 16,
    parameter logic [15:0] IMM_MASK = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [IW-1:0]  in_data,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_onehot,
    output logic [3:0]     out_rfield,
    output logic [IW-1:0]  out_imm,
    output logic           out_illegal,
    output logic [CW-1:0]  cnt_decoded,
    output logic [CW-1:0]  cnt_illegal
);

    state_e         state_q, state_d;
    logic [IW-1:0]  opc_q, opc_d;
    logic [OPW-1:0] onehot_q, onehot_d;
    logic [3:0]     rfield_q, rfield_d;
    logic [IW-1:0]  imm_q, imm_d;
    logic           illegal_q, illegal_d;
    logic [CW-1:0]  cnt_dec_q, cnt_dec_d;
    logic [CW-1:0]  cnt_ill_q, cnt_ill_d;

    logic [IW-1:0]  dec_src;
    logic [3:0]     dec_cls;
    logic [1:0]     dec_sub;
    logic [OPW-1:0] dec_onehot;
    logic           dec_illegal;
    logic           ready_c, valid_c, hs, acc;

    // While waiting for the immediate, the held opcode drives the decoder.
    assign dec_src = (state_q == S_IMM) ? opc_q : in_data;
    assign dec_cls = dec_src[IW-1 -: 4];
    assign dec_sub = dec_src[1:0];

    decode_comb u_decode_comb (
        .cls     (dec_cls),
        .sub     (dec_sub),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        onehot_d  = onehot_q;
        rfield_d  = rfield_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        cnt_dec_d = cnt_dec_q;
        cnt_ill_d = cnt_ill_q;
        ready_c   = 1'b0;
        valid_c   = 1'b0;

        case (state_q)
            S_OPC:   ready_c = 1'b1;
            S_IMM:   ready_c = 1'b1;
            S_OUT: begin
                valid_c = 1'b1;
                ready_c = out_ready;
            end
            default: ready_c = 1'b0;
        endcase
        if (flush) begin
            valid_c = 1'b0;
            ready_c = 1'b0;
        end
        if (!rst_n) ready_c = 1'b0;

        hs  = valid_c & out_ready;
        acc = in_valid & ready_c;

        if (flush) begin
            state_d = S_OPC;
        end else begin
            if (hs) begin
                state_d   = S_OPC;
                cnt_dec_d = (&cnt_dec_q) ? cnt_dec_q : cnt_dec_q + 1'b1;
                if (illegal_q && !(&cnt_ill_q)) cnt_ill_d = cnt_ill_q + 1'b1;
            end
            // An accept in S_OUT only happens together with the handshake,
            // so the reload here overrides the S_OPC return above.
            if (acc) begin
                if (state_q == S_IMM) begin
                    onehot_d  = dec_onehot;
                    rfield_d  = opc_q[3:0];
                    imm_d     = in_data;
                    illegal_d = dec_illegal;
                    state_d   = S_OUT;
                end else if (IMM_MASK[dec_cls] && !dec_illegal) begin
                    opc_d   = in_data;
                    state_d = S_IMM;
                end else begin
                    onehot_d  = dec_onehot;
                    rfield_d  = in_data[3:0];
                    imm_d     = '0;
                    illegal_d = dec_illegal;
                    state_d   = S_OUT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OPC;
            opc_q     <= '0;
            onehot_q  <= '0;
            rfield_q  <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            cnt_dec_q <= '0;
            cnt_ill_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            onehot_q  <= onehot_d;
            rfield_q  <= rfield_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            cnt_dec_q <= cnt_dec_d;
            cnt_ill_q <= cnt_ill_d;
        end
    end

    assign in_ready    = ready_c;
    assign out_valid   = valid_c;
    assign out_onehot  = onehot_q;
    assign out_rfield  = rfield_q;
    assign out_imm     = imm_q;
    assign out_illegal = illegal_q;
    assign cnt_decoded = cnt_dec_q;
    assign cnt_illegal = cnt_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes are queued as bytes are
// driven and popped at each output handshake; a second instance covers CW=2.
module tb_decode_stage;

    typedef struct {
        logic [22:0] oh;
        logic [3:0]  rf;
        logic [7:0]  imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [22:0] out_onehot;
    logic [3:0]  out_rfield;
    logic [7:0]  out_imm;
    logic        out_illegal;
    logic [15:0] cnt_decoded;
    logic [15:0] cnt_illegal;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [22:0] b_out_onehot;
    logic [3:0]  b_out_rfield;
    logic [7:0]  b_out_imm;
    logic        b_out_illegal;
    logic [1:0]  b_cnt_decoded;
    logic [1:0]  b_cnt_illegal;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned b_hs = 0;
    exp_t        sb[$];
    int unsigned hs_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decode_stage #(.IW(8), .CW(16), .IMM_MASK(16'h0020)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_rfield(out_rfield), .out_imm(out_imm),
        .out_illegal(out_illegal),
        .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
    );

    decode_stage #(.IW(8), .CW(2), .IMM_MASK(16'h1000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_onehot(b_out_onehot), .out_rfield(b_out_rfield), .out_imm(b_out_imm),
        .out_illegal(b_out_illegal),
        .cnt_decoded(b_cnt_decoded), .cnt_illegal(b_cnt_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bit_idx < 0 means no one-hot bit (illegal opcode)
    task automatic push_exp(input int bit_idx, input logic [3:0] rf, input logic [7:0] imm, input logic ill);
        exp_t e;
        e.oh  = (bit_idx < 0) ? 23'd0 : (23'd1 << bit_idx);
        e.rf  = rf;
        e.imm = imm;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Call only at posedge+#1; returns at posedge+#1 after the byte is taken.
    task automatic drive_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            exp_t e;
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, {31'd0, out_valid} - 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("onehot", {9'd0, out_onehot}, {9'd0, e.oh});
                check_eq("rfield", {28'd0, out_rfield}, {28'd0, e.rf});
                check_eq("imm", {24'd0, out_imm}, {24'd0, e.imm});
                check_eq("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
        if (b_out_valid && b_out_ready) b_hs <= b_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] bytes[10];
        int         idxs[10];
        int unsigned n_acc;
        bytes = '{8'h00, 8'h13, 8'hC1, 8'hF2, 8'h2A, 8'hB0, 8'hD0, 8'hE3, 8'hF3, 8'hC0};
        idxs  = '{0, 4, 16, 21, 5, 14, 17, 18, 22, 15};

        // reset state
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_onehot", {9'd0, out_onehot}, 32'd0);
        check_eq("rst_rfield", {28'd0, out_rfield}, 32'd0);
        check_eq("rst_imm", {24'd0, out_imm}, 32'd0);
        check_eq("rst_illegal", {31'd0, out_illegal}, 32'd0);
        check_eq("rst_cnt_dec", {16'd0, cnt_decoded}, 32'd0);
        check_eq("rst_cnt_ill", {16'd0, cnt_illegal}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // back-to-back stream, no immediates
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            push_exp(idxs[i], bytes[i][3:0], 8'h00, 1'b0);
            drive_byte(bytes[i]);
        end
        in_valid = 1'b0;
        wait_idle();
        check_eq("stream_hs_count", hs_cyc.size(), 32'd4);
        if (hs_cyc.size() == 4)
            check_eq("stream_spacing", hs_cyc[3] - hs_cyc[0], 32'd3);
        check_eq("cnt_dec_4", {16'd0, cnt_decoded}, 32'd4);

        for (int i = 4; i < 10; i++) begin
            push_exp(idxs[i], bytes[i][3:0], 8'h00, 1'b0);
            drive_byte(bytes[i]);
        end
        in_valid = 1'b0;
        wait_idle();
        check_eq("cnt_dec_10", {16'd0, cnt_decoded}, 32'd10);

        // class 5 takes an immediate
        push_exp(8, 4'h7, 8'hA5, 1'b0);
        drive_byte(8'h57);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("imm_wait_valid", {31'd0, out_valid}, 32'd0);
        check_eq("imm_wait_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive_byte(8'hA5);
        in_valid = 1'b0;
        wait_idle();
        check_eq("cnt_dec_11", {16'd0, cnt_decoded}, 32'd11);

        // illegal opcode
        push_exp(-1, 4'h2, 8'h00, 1'b1);
        drive_byte(8'hC2);
        in_valid = 1'b0;
        wait_idle();
        check_eq("cnt_dec_12", {16'd0, cnt_decoded}, 32'd12);
        check_eq("cnt_ill_1", {16'd0, cnt_illegal}, 32'd1);

        // consumer stall
        out_ready = 1'b0;
        push_exp(19, 4'h0, 8'h00, 1'b0);
        drive_byte(8'hF0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_onehot", {9'd0, out_onehot}, 32'd1 << 19);
            @(posedge clk); #1;
        end
        check_eq("stall_cnt", {16'd0, cnt_decoded}, 32'd12);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("stall_done_valid", {31'd0, out_valid}, 32'd0);
        check_eq("cnt_dec_13", {16'd0, cnt_decoded}, 32'd13);
        @(posedge clk); #1;

        // flush in S_IMM discards the pending opcode and the offered byte
        drive_byte(8'h57);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_flush_cnt", {16'd0, cnt_decoded}, 32'd13);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_byte(8'h13);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_out", {31'd0, out_valid}, 32'd1);
        check_eq("post_flush_onehot", {9'd0, out_onehot}, 32'd1 << 4);
        check_eq("post_flush_rfield", {28'd0, out_rfield}, 32'h3);

        // asynchronous reset while holding an output
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("mid_rst_onehot", {9'd0, out_onehot}, 32'd0);
        check_eq("mid_rst_rfield", {28'd0, out_rfield}, 32'd0);
        check_eq("mid_rst_cnt_dec", {16'd0, cnt_decoded}, 32'd0);
        check_eq("mid_rst_cnt_ill", {16'd0, cnt_illegal}, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("rel2_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rel2_valid", {31'd0, out_valid}, 32'd0);
        check_eq("sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;

        // instance B: illegal class-12 byte never waits for an immediate
        b_in_valid = 1'b1;
        b_in_data  = 8'hC2;
        @(negedge clk);
        check_eq("b_in_ready", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check_eq("b_ill_valid", {31'd0, b_out_valid}, 32'd1);
        check_eq("b_ill_flag", {31'd0, b_out_illegal}, 32'd1);
        check_eq("b_ill_onehot", {9'd0, b_out_onehot}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("b_cnt_ill", {30'd0, b_cnt_illegal}, 32'd1);
        check_eq("b_cnt_dec_1", {30'd0, b_cnt_decoded}, 32'd1);
        @(posedge clk); #1;

        // instance B: counter saturation at CW=2
        n_acc      = 0;
        b_in_valid = 1'b1;
        b_in_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b_in_ready) n_acc++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        check_eq("b_accepts", n_acc, 32'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("b_hs_total", b_hs, 32'd6);
        check_eq("b_cnt_sat", {30'd0, b_cnt_decoded}, 32'd3);
        check_eq("b_cnt_ill_hold", {30'd0, b_cnt_illegal}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
